// File: rtl/fme_refpel_arb_if.sv
// fme_refpel_arb_if
//   Bundles the request/grant/read-beat handshake of the two requesters, the
//   registered read port of the reference-pixel buffer and the flush/error
//   signals of the FME reference-pixel arbiter.
//   Ports of the arbiter (slave modport):
//     start_i               LCU start, synchronous flush
//     rN_req_i / rN_gnt_o   burst request / ownership, N = 0 (luma), 1 (chroma)
//     rN_rden_i, rN_x_i/y_i read beat and pixel index from requester N
//     rN_vld_o              buffer data valid for requester N
//     mem_rden_o, mem_x_o/y_o buffer read enable and index
//     err_o                 one-cycle pulse on a read beat from a non-owner
interface fme_refpel_arb_if #(
   parameter int ADDR_W = 7
);
   logic              start_i;
   logic              r0_req_i;
   logic              r0_gnt_o;
   logic              r0_rden_i;
   logic [ADDR_W-1:0] r0_x_i;
   logic [ADDR_W-1:0] r0_y_i;
   logic              r0_vld_o;
   logic              r1_req_i;
   logic              r1_gnt_o;
   logic              r1_rden_i;
   logic [ADDR_W-1:0] r1_x_i;
   logic [ADDR_W-1:0] r1_y_i;
   logic              r1_vld_o;
   logic              mem_rden_o;
   logic [ADDR_W-1:0] mem_x_o;
   logic [ADDR_W-1:0] mem_y_o;
   logic              err_o;

   // requester/memory side
   modport master (
      output start_i,
      output r0_req_i, r0_rden_i, r0_x_i, r0_y_i,
      output r1_req_i, r1_rden_i, r1_x_i, r1_y_i,
      input  r0_gnt_o, r0_vld_o, r1_gnt_o, r1_vld_o,
      input  mem_rden_o, mem_x_o, mem_y_o, err_o
   );

   // arbiter side
   modport slave (
      input  start_i,
      input  r0_req_i, r0_rden_i, r0_x_i, r0_y_i,
      input  r1_req_i, r1_rden_i, r1_x_i, r1_y_i,
      output r0_gnt_o, r0_vld_o, r1_gnt_o, r1_vld_o,
      output mem_rden_o, mem_x_o, mem_y_o, err_o
   );
endinterface

// File: rtl/fme_refpel_arb.sv
// fme_refpel_arb
//   Arbiter for the single read port of the FME reference-pixel buffer.
//   r0 (FME luma fetch) has priority over r1 (chroma MC fetch); ownership is
//   granted for fixed bursts of BURST_LEN read beats, and a starvation counter
//   forces an r1 grant after STARVE_MAX consecutive r0 grants while r1 waits.
//   The owner's beats are registered onto the memory port; a two-stage tag
//   pipeline returns per-requester valid strobes two cycles after each beat.
//   Ports:
//     clk   clock
//     rst   asynchronous active-high reset
//     bus   fme_refpel_arb_if.slave (handshake, memory port, flush, error)
module fme_refpel_arb #(
   parameter int ADDR_W     = 7,
   parameter int BURST_LEN  = 16,
   parameter int STARVE_MAX = 4
) (
   input logic              clk,
   input logic              rst,
   fme_refpel_arb_if.slave  bus
);

   localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t            state, state_nxt, arb_sel;
   logic [CW-1:0]     beat_cnt, beat_nxt;
   logic [SW-1:0]     starve, starve_nxt;
   logic              arb_eval;
   logic              own_rden;
   logic              own_id;
   logic [ADDR_W-1:0] own_x, own_y;
   logic              err_d;
   logic              tag1_id;

   assign bus.r0_gnt_o = (state == GNT0);
   assign bus.r1_gnt_o = (state == GNT1);

   always_comb begin
      arb_sel    = IDLE;
      own_rden   = 1'b0;
      own_id     = 1'b0;
      own_x      = bus.r0_x_i;
      own_y      = bus.r0_y_i;
      err_d      = 1'b0;
      arb_eval   = 1'b0;
      state_nxt  = state;
      beat_nxt   = beat_cnt;
      starve_nxt = starve;

      // arbitration function A
      if (bus.r0_req_i && (!bus.r1_req_i || (starve < SW'(STARVE_MAX))))
         arb_sel = GNT0;
      else if (bus.r1_req_i)
         arb_sel = GNT1;

      // owner mux; the non-owner's beat only raises err_d
      if (state == GNT1) begin
         own_rden = bus.r1_rden_i;
         own_id   = 1'b1;
         own_x    = bus.r1_x_i;
         own_y    = bus.r1_y_i;
      end else if (state == GNT0) begin
         own_rden = bus.r0_rden_i;
      end
      err_d = (bus.r0_rden_i && (state != GNT0)) ||
              (bus.r1_rden_i && (state != GNT1));

      case (state)
         IDLE: arb_eval = 1'b1;
         GNT0, GNT1: begin
            if (own_rden) begin
               if (beat_cnt == CW'(BURST_LEN - 1)) begin
                  beat_nxt = '0;
                  arb_eval = 1'b1;
               end else begin
                  beat_nxt = beat_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      // starvation bookkeeping is tied to the grant decision itself, so a
      // back-to-back r0 re-grant counts as a fresh entry into GNT0
      if (arb_eval) begin
         state_nxt = arb_sel;
         if (arb_sel == GNT0 && bus.r1_req_i)
            starve_nxt = (starve == SW'(STARVE_MAX)) ? starve : starve + 1'b1;
         else if (arb_sel == GNT1)
            starve_nxt = '0;
      end

      if (bus.start_i) begin
         state_nxt  = IDLE;
         beat_nxt   = '0;
         starve_nxt = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         beat_cnt <= '0;
         starve   <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_nxt;
         starve   <= starve_nxt;
      end
   end

   // memory port is tag stage 1 (valid = mem_rden_o); stage 2 drives the strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mem_rden_o <= 1'b0;
         bus.mem_x_o    <= '0;
         bus.mem_y_o    <= '0;
         tag1_id        <= 1'b0;
         bus.r0_vld_o   <= 1'b0;
         bus.r1_vld_o   <= 1'b0;
         bus.err_o      <= 1'b0;
      end else if (bus.start_i) begin
         bus.mem_rden_o <= 1'b0;
         bus.mem_x_o    <= '0;
         bus.mem_y_o    <= '0;
         tag1_id        <= 1'b0;
         bus.r0_vld_o   <= 1'b0;
         bus.r1_vld_o   <= 1'b0;
         bus.err_o      <= 1'b0;
      end else begin
         bus.mem_rden_o <= own_rden;
         if (own_rden) begin
            bus.mem_x_o <= own_x;
            bus.mem_y_o <= own_y;
         end
         tag1_id      <= own_id;
         bus.r0_vld_o <= bus.mem_rden_o && !tag1_id;
         bus.r1_vld_o <= bus.mem_rden_o &&  tag1_id;
         bus.err_o    <= err_d;
      end
   end

endmodule

// File: tb/tb_fme_refpel_arb.sv
// tb_fme_refpel_arb
//   Drives the arbiter through directed scenarios (single burst, back-to-back
//   bursts, starvation, protocol error, flush, async reset) and a randomized
//   phase, comparing every output each cycle to a behavioural model.
module tb_fme_refpel_arb;

   localparam int ADDR_W     = 7;
   localparam int BURST_LEN  = 16;
   localparam int STARVE_MAX = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int total = 0;
   int bad   = 0;

   fme_refpel_arb_if #(.ADDR_W(ADDR_W)) bus ();

   fme_refpel_arb #(
      .ADDR_W    (ADDR_W),
      .BURST_LEN (BURST_LEN),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // behavioural model: owner 0=none, 1=r0, 2=r1
   int m_owner, m_beats, m_starve, m_prev_acc;
   int e_mem_rden, e_mem_x, e_mem_y, e_vld0, e_vld1, e_err;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_owner = 0; m_beats = 0; m_starve = 0; m_prev_acc = 0;
      e_mem_rden = 0; e_mem_x = 0; e_mem_y = 0;
      e_vld0 = 0; e_vld1 = 0; e_err = 0;
   endtask

   function automatic int arbitrate();
      if (bus.r0_req_i && (!bus.r1_req_i || m_starve < STARVE_MAX)) return 1;
      if (bus.r1_req_i) return 2;
      return 0;
   endfunction

   task automatic model_step();
      int acc, nxt;
      bit decide;
      if (bus.start_i) begin
         model_clear();
         return;
      end
      acc = 0;
      if (m_owner == 1 && bus.r0_rden_i) acc = 1;
      if (m_owner == 2 && bus.r1_rden_i) acc = 2;
      e_err  = ((bus.r0_rden_i && m_owner != 1) || (bus.r1_rden_i && m_owner != 2)) ? 1 : 0;
      e_vld0 = (m_prev_acc == 1) ? 1 : 0;
      e_vld1 = (m_prev_acc == 2) ? 1 : 0;
      m_prev_acc = acc;
      e_mem_rden = (acc != 0) ? 1 : 0;
      if (acc == 1) begin e_mem_x = bus.r0_x_i; e_mem_y = bus.r0_y_i; end
      if (acc == 2) begin e_mem_x = bus.r1_x_i; e_mem_y = bus.r1_y_i; end
      decide = (m_owner == 0);
      if (acc != 0) begin
         m_beats++;
         if (m_beats == BURST_LEN) begin
            m_beats = 0;
            decide  = 1;
         end
      end
      if (decide) begin
         nxt = arbitrate();
         if (nxt == 1 && bus.r1_req_i) m_starve = (m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX;
         if (nxt == 2) m_starve = 0;
         m_owner = nxt;
      end
   endtask

   task automatic check_all();
      chk("r0_gnt",   bus.r0_gnt_o,   (m_owner == 1) ? 1 : 0);
      chk("r1_gnt",   bus.r1_gnt_o,   (m_owner == 2) ? 1 : 0);
      chk("mem_rden", bus.mem_rden_o, e_mem_rden);
      chk("mem_x",    bus.mem_x_o,    e_mem_x);
      chk("mem_y",    bus.mem_y_o,    e_mem_y);
      chk("r0_vld",   bus.r0_vld_o,   e_vld0);
      chk("r1_vld",   bus.r1_vld_o,   e_vld1);
      chk("err",      bus.err_o,      e_err);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic drv(input bit q0, input bit q1, input bit d0, input bit d1, input bit st);
      bus.r0_req_i  = q0;
      bus.r1_req_i  = q1;
      bus.r0_rden_i = d0;
      bus.r1_rden_i = d1;
      bus.start_i   = st;
      bus.r0_x_i    = ADDR_W'($urandom);
      bus.r0_y_i    = ADDR_W'($urandom);
      bus.r1_x_i    = ADDR_W'($urandom);
      bus.r1_y_i    = ADDR_W'($urandom);
   endtask

   initial begin
      int owner_code;
      model_clear();
      drv(0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_all();
      tick();

      // single r0 burst, y = 12..27
      drv(1, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < BURST_LEN; i++) begin
         drv(0, 0, 1, 0, 0);
         bus.r0_y_i = ADDR_W'(12 + i);
         tick();
      end
      drv(0, 0, 0, 0, 0);
      repeat (3) tick();

      // back-to-back r0 bursts, r1 silent
      for (int i = 0; i < 3 * BURST_LEN + 1; i++) begin
         drv(1, 0, (m_owner == 1), 0, 0);
         tick();
      end

      // starvation: flush to a known starve value, then both request
      drv(1, 1, 0, 0, 1);
      tick();
      drv(1, 1, 0, 0, 0);
      tick();
      for (int k = 0; k < 10; k++) begin
         owner_code = bus.r0_gnt_o ? 1 : (bus.r1_gnt_o ? 2 : 0);
         chk("starve_seq", owner_code, (k % (STARVE_MAX + 1) == STARVE_MAX) ? 2 : 1);
         for (int b = 0; b < BURST_LEN; b++) begin
            drv(1, 1, (m_owner == 1), (m_owner == 2), 0);
            tick();
         end
      end

      // protocol error: r1 reads during an r0 burst
      drv(0, 0, 0, 0, 1);
      tick();
      drv(1, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < BURST_LEN; i++) begin
         drv(0, 0, 1, (i % 5 == 2), 0);
         tick();
      end
      drv(0, 0, 0, 1, 0);
      repeat (2) tick();

      // flush at beat 7 of an r1 burst with r0 pending
      drv(0, 1, 0, 0, 0);
      tick();
      for (int i = 0; i < 7; i++) begin
         drv(0, 0, 0, 1, 0);
         tick();
      end
      drv(1, 0, 0, 1, 1);
      tick();
      chk("flush_idle", bus.r1_gnt_o, 0);
      drv(1, 0, 0, 0, 0);
      tick();
      chk("flush_regrant", bus.r0_gnt_o, 1);
      repeat (3) begin
         drv(0, 0, 0, 0, 0);
         tick();
      end

      // async reset mid-burst (model owns r0 after the flush test)
      for (int i = 0; i < 5; i++) begin
         drv(0, 0, 1, 0, 0);
         tick();
      end
      @(posedge clk);
      model_step();
      #2 rst = 1'b1;
      #1;
      chk("rst_gnt0", bus.r0_gnt_o, 0);
      chk("rst_mem",  bus.mem_rden_o, 0);
      chk("rst_memy", bus.mem_y_o, 0);
      chk("rst_vld0", bus.r0_vld_o, 0);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      drv(1, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < BURST_LEN; i++) begin
         drv(0, 0, 1, 0, 0);
         tick();
      end
      drv(0, 0, 0, 0, 0);
      repeat (3) tick();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         drv(($urandom % 4) != 0,
             ($urandom % 3) == 0,
             (m_owner == 1) ? (($urandom % 4) != 0) : (($urandom % 16) == 0),
             (m_owner == 2) ? (($urandom % 4) != 0) : (($urandom % 16) == 0),
             ($urandom % 200) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
